// File: rtl/req_dispatch_queue_pkg.sv
// Shared request types for the control group: the CPU-to-control request
// record and the FIFO entry that stores it without its valid bit.
package req_dispatch_queue_pkg;

  localparam int REQ_ADDR_W      = 10;
  localparam int REQ_OPCODE_W    = 2;
  localparam int REQ_WIDTH_ENC_W = 3;

  typedef struct packed {
    logic                       valid;
    logic [REQ_OPCODE_W-1:0]    opcode;
    logic [REQ_ADDR_W-1:0]      key_addr;
    logic [REQ_ADDR_W-1:0]      text_addr;
    logic [REQ_WIDTH_ENC_W-1:0] text_width;
  } cpu_to_control_req_if;

  typedef struct packed {
    logic [REQ_OPCODE_W-1:0]    opcode;
    logic [REQ_ADDR_W-1:0]      key_addr;
    logic [REQ_ADDR_W-1:0]      text_addr;
    logic [REQ_WIDTH_ENC_W-1:0] text_width;
  } cpu_req_entry_t;

  function automatic cpu_to_control_req_if to_req(cpu_req_entry_t e, logic v);
    cpu_to_control_req_if r;
    r.valid      = v;
    r.opcode     = e.opcode;
    r.key_addr   = e.key_addr;
    r.text_addr  = e.text_addr;
    r.text_width = e.text_width;
    return r;
  endfunction

endpackage

// File: rtl/req_dispatch_queue_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// searching upward with wrap. Shared with the NoC arbiter.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]                         req,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
  output logic [N-1:0]                         grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] gidx
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic          found;
  logic [PW-1:0] sel;
  int            idx;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      sel = PW'(idx);
      if (!found && req[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        gidx       = sel;
      end
    end
  end

endmodule

// File: rtl/req_dispatch_queue.sv
// CPU request FIFO that hands its head entry to one idle control FSM per
// cycle, rotating fairly among the FSMs reporting ready_for_req.
module req_dispatch_queue
  import req_dispatch_queue_pkg::*;
#(
  parameter int ADDR_W            = REQ_ADDR_W,
  parameter int CPU_OPCODE_W      = REQ_OPCODE_W,
  parameter int ADDR_W_ENCODING_W = REQ_WIDTH_ENC_W,
  parameter int DEPTH             = 4,
  parameter int NUM_FSM           = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cpu_valid,
  output logic                                cpu_ready,
  input  logic [CPU_OPCODE_W-1:0]             cpu_opcode,
  input  logic [ADDR_W-1:0]                   cpu_key_addr,
  input  logic [ADDR_W-1:0]                   cpu_text_addr,
  input  logic [ADDR_W_ENCODING_W-1:0]        cpu_text_width,
  output cpu_to_control_req_if [NUM_FSM-1:0]  fsm_req,
  input  logic [NUM_FSM-1:0]                  fsm_ready,
  output logic [$clog2(DEPTH+1)-1:0]          count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = (NUM_FSM > 1) ? $clog2(NUM_FSM) : 1;

  cpu_req_entry_t       mem [DEPTH];
  cpu_req_entry_t       head;
  cpu_req_entry_t       wr_entry;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [RW-1:0]        rr_ptr;
  logic [RW-1:0]        gidx;
  logic [NUM_FSM-1:0]   req_vec;
  logic [NUM_FSM-1:0]   grant;
  logic                 push;
  logic                 pop;
  logic [CW-1:0]        count_next;

  assign push = cpu_valid & cpu_ready;

  // Ready FSMs only compete while there is something to hand out.
  assign req_vec = (count != '0) ? fsm_ready : '0;
  assign pop     = |req_vec;
  assign head    = mem[rd_ptr];

  assign wr_entry.opcode     = cpu_opcode;
  assign wr_entry.key_addr   = cpu_key_addr;
  assign wr_entry.text_addr  = cpu_text_addr;
  assign wr_entry.text_width = cpu_text_width;

  rr_pick #(
    .N(NUM_FSM)
  ) u_rr_pick (
    .req  (req_vec),
    .ptr  (rr_ptr),
    .grant(grant),
    .gidx (gidx)
  );

  for (genvar i = 0; i < NUM_FSM; i++) begin : g_req
    assign fsm_req[i] = to_req(head, grant[i]);
  end

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (!push && pop) begin
      count_next = count - 1'b1;
    end
  end

  // Storage needs no reset; only entries below count are ever presented.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rr_ptr    <= '0;
      count     <= '0;
      cpu_ready <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        rr_ptr <= (gidx == RW'(NUM_FSM - 1)) ? '0 : gidx + 1'b1;
      end
      count     <= count_next;
      cpu_ready <= (count_next != CW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_req_dispatch_queue.sv
// Directed bench for req_dispatch_queue: a queue-based reference model is
// compared against the DUT every cycle, plus hand-computed spot checks.
module tb_req_dispatch_queue;
  import req_dispatch_queue_pkg::*;

  localparam int DEPTH   = 4;
  localparam int NUM_FSM = 4;

  logic                              clk = 1'b0;
  logic                              rst_n = 1'b0;
  logic                              cpu_valid = 1'b0;
  logic                              cpu_ready;
  logic [1:0]                        cpu_opcode = '0;
  logic [9:0]                        cpu_key_addr = '0;
  logic [9:0]                        cpu_text_addr = '0;
  logic [2:0]                        cpu_text_width = '0;
  cpu_to_control_req_if [NUM_FSM-1:0] fsm_req;
  logic [NUM_FSM-1:0]                fsm_ready = 4'b1111;
  logic [2:0]                        count;

  int checks = 0;
  int passes = 0;

  cpu_req_entry_t m_q[$];
  int             m_rr = 0;
  bit             m_ready = 1'b0;
  int             mg;
  cpu_req_entry_t me;

  req_dispatch_queue #(
    .DEPTH  (DEPTH),
    .NUM_FSM(NUM_FSM)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_valid     (cpu_valid),
    .cpu_ready     (cpu_ready),
    .cpu_opcode    (cpu_opcode),
    .cpu_key_addr  (cpu_key_addr),
    .cpu_text_addr (cpu_text_addr),
    .cpu_text_width(cpu_text_width),
    .fsm_req       (fsm_req),
    .fsm_ready     (fsm_ready),
    .count         (count)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Expected winner: first ready FSM from the rotation pointer, if anything queued.
  function automatic int modelGrant();
    if (m_q.size() == 0) return -1;
    for (int k = 0; k < NUM_FSM; k++) begin
      if (fsm_ready[(m_rr + k) % NUM_FSM]) return (m_rr + k) % NUM_FSM;
    end
    return -1;
  endfunction

  function automatic int dutGrant();
    int g = -1;
    int n = 0;
    for (int i = 0; i < NUM_FSM; i++) begin
      if (fsm_req[i].valid) begin
        g = i;
        n++;
      end
    end
    if (n > 1) return -2;
    return g;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_rr    = 0;
      m_ready = 1'b0;
    end else begin
      mg = modelGrant();
      if (mg >= 0) begin
        void'(m_q.pop_front());
        m_rr = (mg + 1) % NUM_FSM;
      end
      if (cpu_valid && m_ready) begin
        me.opcode     = cpu_opcode;
        me.key_addr   = cpu_key_addr;
        me.text_addr  = cpu_text_addr;
        me.text_width = cpu_text_width;
        m_q.push_back(me);
      end
      m_ready = (m_q.size() != DEPTH);
    end
  end

  task automatic checkOutput();
    int g;
    cpu_req_entry_t d;
    checkVal("cpu_ready", int'(cpu_ready), int'(m_ready));
    checkVal("count", int'(count), m_q.size());
    g = modelGrant();
    for (int i = 0; i < NUM_FSM; i++) begin
      checkVal($sformatf("valid[%0d]", i), int'(fsm_req[i].valid), (i == g) ? 1 : 0);
      if (m_q.size() > 0) begin
        d.opcode     = fsm_req[i].opcode;
        d.key_addr   = fsm_req[i].key_addr;
        d.text_addr  = fsm_req[i].text_addr;
        d.text_width = fsm_req[i].text_width;
        checkVal($sformatf("data[%0d]", i), int'(d), int'(m_q[0]));
      end
    end
  endtask

  always @(negedge clk) checkOutput();

  task automatic applyStimulus(input bit v, input logic [1:0] op, input logic [9:0] k,
                               input logic [9:0] t, input logic [2:0] w,
                               input logic [3:0] rdy);
    @(posedge clk);
    #1;
    cpu_valid      = v;
    cpu_opcode     = op;
    cpu_key_addr   = k;
    cpu_text_addr  = t;
    cpu_text_width = w;
    fsm_ready      = rdy;
    #2;
  endtask

  initial begin
    #1;
    checkVal("reset_ready", int'(cpu_ready), 0);
    checkVal("reset_count", int'(count), 0);
    checkVal("reset_grant", dutGrant(), -1);
    applyStimulus(0, 0, 0, 0, 0, 4'hF);
    applyStimulus(0, 0, 0, 0, 0, 4'hF);
    rst_n = 1'b1;
    checkVal("ready_before_edge", int'(cpu_ready), 0);

    // Back-to-back dispatch while all FSMs idle.
    applyStimulus(1, 2'd2, 10'h010, 10'h200, 3'd3, 4'hF);
    checkVal("ready_after_release", int'(cpu_ready), 1);
    applyStimulus(1, 2'd1, 10'h011, 10'h201, 3'd1, 4'hF);
    checkVal("first_grant", dutGrant(), 0);
    checkVal("first_opcode", int'(fsm_req[0].opcode), 2);
    checkVal("first_key", int'(fsm_req[0].key_addr), 'h010);
    checkVal("first_text", int'(fsm_req[0].text_addr), 'h200);
    checkVal("first_width", int'(fsm_req[0].text_width), 3);
    checkVal("first_count", int'(count), 1);
    applyStimulus(1, 2'd3, 10'h012, 10'h202, 3'd2, 4'hF);
    checkVal("second_grant", dutGrant(), 1);
    checkVal("second_key", int'(fsm_req[1].key_addr), 'h011);
    applyStimulus(1, 2'd0, 10'h013, 10'h203, 3'd4, 4'hF);
    checkVal("third_grant", dutGrant(), 2);
    applyStimulus(0, 0, 0, 0, 0, 4'hF);
    checkVal("fourth_grant", dutGrant(), 3);
    checkVal("fourth_key", int'(fsm_req[3].key_addr), 'h013);

    // Fill with no FSM ready; a fifth offer must be held off.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 2'(k), 10'(32'h020 + k), 10'(32'h300 + k), 3'(k), 4'h0);
      checkVal("fill_nogrant", dutGrant(), -1);
    end
    applyStimulus(1, 2'd3, 10'h0FF, 10'h3FF, 3'd7, 4'h0);
    checkVal("full_count", int'(count), 4);
    checkVal("full_ready", int'(cpu_ready), 0);
    applyStimulus(1, 2'd3, 10'h0FF, 10'h3FF, 3'd7, 4'h0);
    checkVal("full_hold", int'(count), 4);

    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 4'hF);
      checkVal("drain_grant", dutGrant(), k);
      checkVal("drain_key", int'(fsm_req[k].key_addr), 'h020 + k);
    end
    applyStimulus(0, 0, 0, 0, 0, 4'hF);
    checkVal("drained_count", int'(count), 0);
    checkVal("drained_ready", int'(cpu_ready), 1);

    // Move rotation to 2, then offer only FSMs 0 and 1.
    applyStimulus(1, 2'd1, 10'h050, 10'h150, 3'd1, 4'hF);
    applyStimulus(1, 2'd2, 10'h051, 10'h151, 3'd2, 4'hF);
    checkVal("rot_a", dutGrant(), 0);
    applyStimulus(0, 0, 0, 0, 0, 4'hF);
    checkVal("rot_b", dutGrant(), 1);
    applyStimulus(1, 2'd3, 10'h052, 10'h152, 3'd3, 4'b0011);
    applyStimulus(0, 0, 0, 0, 0, 4'b0011);
    checkVal("wrap_grant", dutGrant(), 0);
    applyStimulus(1, 2'd0, 10'h053, 10'h153, 3'd4, 4'hF);
    applyStimulus(0, 0, 0, 0, 0, 4'hF);
    checkVal("after_wrap_grant", dutGrant(), 1);

    // Steady state: push and pop every cycle at two entries.
    applyStimulus(1, 2'd0, 10'h060, 10'h160, 3'd0, 4'h0);
    applyStimulus(1, 2'd1, 10'h061, 10'h161, 3'd1, 4'h0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1, 2'(k), 10'(32'h062 + k), 10'(32'h162 + k), 3'(k), 4'hF);
      checkVal("steady_count", int'(count), 2);
    end
    applyStimulus(0, 0, 0, 0, 0, 4'hF);
    applyStimulus(0, 0, 0, 0, 0, 4'hF);
    applyStimulus(0, 0, 0, 0, 0, 4'hF);
    checkVal("steady_drained", int'(count), 0);

    // Reset in the middle of a dispatch with three entries queued.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 2'(k), 10'(32'h070 + k), 10'(32'h170 + k), 3'(k), 4'h0);
    end
    applyStimulus(0, 0, 0, 0, 0, 4'hF);
    checkVal("pre_reset_count", int'(count), 3);
    rst_n = 1'b0;
    #1;
    checkVal("mid_reset_grant", dutGrant(), -1);
    checkVal("mid_reset_count", int'(count), 0);
    checkVal("mid_reset_ready", int'(cpu_ready), 0);
    applyStimulus(0, 0, 0, 0, 0, 4'hF);
    rst_n = 1'b1;
    applyStimulus(1, 2'd1, 10'h3AA, 10'h155, 3'd5, 4'hF);
    checkVal("post_reset_ready", int'(cpu_ready), 1);
    applyStimulus(0, 0, 0, 0, 0, 4'hF);
    checkVal("post_reset_grant", dutGrant(), 0);
    checkVal("post_reset_key", int'(fsm_req[0].key_addr), 'h3AA);
    applyStimulus(0, 0, 0, 0, 0, 4'hF);
    checkVal("post_reset_count", int'(count), 0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
